// File: rtl/decryption_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decryption_pkg
// Description : Shared constants and message-FSM state encoding for the
//               decryption output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package decryption_pkg;

    localparam int DATA_WIDTH       = 8;
    localparam int DEFAULT_DEPTH    = 16;
    localparam int DEFAULT_IDLE_GAP = 4;

    // Input-side message tracking states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        GAP  = 2'd2
    } msg_state_e;

endpackage : decryption_pkg
`default_nettype wire

// File: rtl/sync_fifo_fwft.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_fwft
// Description : Single-clock first-word-fall-through FIFO. The head entry is
//               presented on rdata whenever the FIFO is non-empty; rdata is
//               forced to zero when empty.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               push, wdata   - write strobe (caller guarantees space) / data
//               pop           - consume head (caller guarantees non-empty)
//               rdata         - head-of-FIFO data, 0 when empty
//               full, empty   - level == DEPTH / level == 0
//               level         - number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_fwft #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_W:0]       level
);

    logic [DATA_WIDTH-1:0] r_mem_q [DEPTH];
    logic [ADDR_W-1:0]     r_wr_ptr_q, w_wr_ptr_d;
    logic [ADDR_W-1:0]     r_rd_ptr_q, w_rd_ptr_d;
    logic [ADDR_W:0]       r_level_q,  w_level_d;

    always_comb begin
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_level_d  = r_level_q;
        // Pointers are ADDR_W bits wide, so they wrap modulo DEPTH naturally
        if (push) w_wr_ptr_d = r_wr_ptr_q + 1'b1;
        if (pop)  w_rd_ptr_d = r_rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   w_level_d = r_level_q + 1'b1;
            2'b01:   w_level_d = r_level_q - 1'b1;
            default: w_level_d = r_level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr_q <= '0;
            r_rd_ptr_q <= '0;
            r_level_q  <= '0;
        end else begin
            r_wr_ptr_q <= w_wr_ptr_d;
            r_rd_ptr_q <= w_rd_ptr_d;
            r_level_q  <= w_level_d;
        end
    end

    // Storage needs no reset: rdata is masked while the FIFO is empty
    always_ff @(posedge clk) begin
        if (push) r_mem_q[r_wr_ptr_q] <= wdata;
    end

    assign level = r_level_q;
    assign empty = (r_level_q == '0);
    assign full  = (r_level_q == (ADDR_W+1)'(DEPTH));
    assign rdata = empty ? '0 : r_mem_q[r_rd_ptr_q];

endmodule : sync_fifo_fwft
`default_nettype wire

// File: rtl/decryption_out_buffer.sv
`default_nettype none
// ============================================================================
// Module      : decryption_out_buffer
// Description : Buffers the decrypted character stream in a FWFT FIFO,
//               drains it over valid/ready, flags dropped characters with a
//               sticky overflow bit, and closes messages after an idle gap,
//               reporting the accepted-character count of each message.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               data_i, valid_i     - upstream character stream (no backpressure)
//               data_o, valid_o     - head-of-FIFO character / FIFO not empty
//               ready_i             - consumer accepts data_o
//               full, empty, level  - FIFO status
//               msg_done, msg_len   - one-cycle close pulse / last message length
//               overflow, clear_ovf - sticky drop flag / clear request
// Revision    : 1.0 - initial release
// ============================================================================
module decryption_out_buffer
    import decryption_pkg::*;
#(
    parameter int DATA_WIDTH = decryption_pkg::DATA_WIDTH,
    parameter int DEPTH      = decryption_pkg::DEFAULT_DEPTH,
    parameter int ADDR_W     = 4,
    parameter int LEN_WIDTH  = 8,
    parameter int IDLE_GAP   = decryption_pkg::DEFAULT_IDLE_GAP
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_W:0]       level,
    output logic                  msg_done,
    output logic [LEN_WIDTH-1:0]  msg_len,
    output logic                  overflow,
    input  logic                  clear_ovf
);

    localparam int c_gap_w = $clog2(IDLE_GAP + 1);
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(IDLE_GAP - 1);

    logic w_push, w_pop, w_drop;

    msg_state_e            r_state_q,    w_state_d;
    logic [LEN_WIDTH-1:0]  r_len_cnt_q,  w_len_cnt_d;
    logic [c_gap_w-1:0]    r_gap_cnt_q,  w_gap_cnt_d;
    logic                  r_msg_done_q, w_msg_done_d;
    logic [LEN_WIDTH-1:0]  r_msg_len_q,  w_msg_len_d;
    logic                  r_ovf_q,      w_ovf_d;
    logic [LEN_WIDTH-1:0]  w_len_inc;

    // A full FIFO still accepts a character if the head leaves this cycle
    assign w_pop  = ~empty & ready_i;
    assign w_push = valid_i & (~full | w_pop);
    assign w_drop = valid_i & full & ~w_pop;

    sync_fifo_fwft #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .wdata (data_i),
        .pop   (w_pop),
        .rdata (data_o),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    assign valid_o = ~empty;

    // Saturating length increment
    assign w_len_inc = (r_len_cnt_q == '1) ? r_len_cnt_q : r_len_cnt_q + 1'b1;

    always_comb begin
        w_state_d    = r_state_q;
        w_len_cnt_d  = r_len_cnt_q;
        w_gap_cnt_d  = r_gap_cnt_q;
        w_msg_done_d = 1'b0;
        w_msg_len_d  = r_msg_len_q;

        // A drop in the same cycle as a clear wins so no loss goes unreported
        if (w_drop)         w_ovf_d = 1'b1;
        else if (clear_ovf) w_ovf_d = 1'b0;
        else                w_ovf_d = r_ovf_q;

        case (r_state_q)
            IDLE: begin
                // Only an accepted character opens a message
                if (w_push) begin
                    w_state_d   = RECV;
                    w_len_cnt_d = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
                end
            end
            RECV: begin
                if (w_push) w_len_cnt_d = w_len_inc;
                if (!valid_i) begin
                    w_state_d   = GAP;
                    w_gap_cnt_d = {{(c_gap_w-1){1'b0}}, 1'b1};
                end
            end
            GAP: begin
                if (valid_i) begin
                    w_state_d   = RECV;
                    w_gap_cnt_d = '0;
                    if (w_push) w_len_cnt_d = w_len_inc;
                // ">=" lets IDLE_GAP == 1 close on the first GAP cycle
                end else if (r_gap_cnt_q >= c_gap_last) begin
                    w_state_d    = IDLE;
                    w_gap_cnt_d  = '0;
                    w_msg_done_d = 1'b1;
                    w_msg_len_d  = r_len_cnt_q;
                end else begin
                    w_gap_cnt_d = r_gap_cnt_q + 1'b1;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= IDLE;
            r_len_cnt_q  <= '0;
            r_gap_cnt_q  <= '0;
            r_msg_done_q <= 1'b0;
            r_msg_len_q  <= '0;
            r_ovf_q      <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_len_cnt_q  <= w_len_cnt_d;
            r_gap_cnt_q  <= w_gap_cnt_d;
            r_msg_done_q <= w_msg_done_d;
            r_msg_len_q  <= w_msg_len_d;
            r_ovf_q      <= w_ovf_d;
        end
    end

    assign msg_done = r_msg_done_q;
    assign msg_len  = r_msg_len_q;
    assign overflow = r_ovf_q;

endmodule : decryption_out_buffer
`default_nettype wire

// File: tb/tb_decryption_out_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_decryption_out_buffer
// Description : Self-checking bench for decryption_out_buffer: a vector table
//               for a basic message, directed corner sequences, and random
//               traffic, all compared against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decryption_out_buffer;

    localparam int DW       = 8;
    localparam int DEPTH    = 16;
    localparam int AW       = 4;
    localparam int LW       = 8;
    localparam int IDLE_GAP = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data_i = '0;
    logic          valid_i = 1'b0;
    logic          ready_i = 1'b0;
    logic          clear_ovf = 1'b0;
    logic [DW-1:0] data_o;
    logic          valid_o, full, empty, msg_done, overflow;
    logic [AW:0]   level;
    logic [LW-1:0] msg_len;

    decryption_out_buffer #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .ADDR_W     (AW),
        .LEN_WIDTH  (LW),
        .IDLE_GAP   (IDLE_GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .full      (full),
        .empty     (empty),
        .level     (level),
        .msg_done  (msg_done),
        .msg_len   (msg_len),
        .overflow  (overflow),
        .clear_ovf (clear_ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] mq[$];
    int m_ovf, m_in_msg, m_cnt, m_idle, m_done, m_len;

    task automatic model_step();
        bit pop, push, drop;
        if (rst) begin
            mq.delete();
            m_ovf = 0; m_in_msg = 0; m_cnt = 0; m_idle = 0; m_done = 0; m_len = 0;
            return;
        end
        pop  = (mq.size() > 0) && ready_i;
        push = valid_i && ((mq.size() < DEPTH) || pop);
        drop = valid_i && !push;
        if (pop)  void'(mq.pop_front());
        if (push) mq.push_back(data_i);
        if (drop) m_ovf = 1;
        else if (clear_ovf) m_ovf = 0;
        m_done = 0;
        if (valid_i) begin
            m_idle = 0;
            if (push) begin
                if (!m_in_msg) begin
                    m_in_msg = 1;
                    m_cnt    = 1;
                end else if (m_cnt < (1 << LW) - 1) begin
                    m_cnt++;
                end
            end
        end else if (m_in_msg) begin
            m_idle++;
            if (m_idle == IDLE_GAP) begin
                m_done   = 1;
                m_len    = m_cnt;
                m_in_msg = 0;
                m_idle   = 0;
            end
        end
    endtask

    task automatic model_check();
        int sz;
        sz = mq.size();
        chk("m_level",    int'(level),    sz);
        chk("m_empty",    int'(empty),    int'(sz == 0));
        chk("m_full",     int'(full),     int'(sz == DEPTH));
        chk("m_valid_o",  int'(valid_o),  int'(sz != 0));
        chk("m_data_o",   int'(data_o),   (sz != 0) ? int'(mq[0]) : 0);
        chk("m_msg_done", int'(msg_done), m_done);
        chk("m_msg_len",  int'(msg_len),  m_len);
        chk("m_overflow", int'(overflow), m_ovf);
    endtask

    // One clock: model follows the edge, outputs sampled 1 ns later
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        model_check();
    endtask

    task automatic drive(input bit v, input int d, input bit r, input bit c);
        valid_i   = v;
        data_i    = DW'(d);
        ready_i   = r;
        clear_ovf = c;
    endtask

    typedef struct {
        bit v; int d; bit r;
        int e_level; int e_data; bit e_valid; bit e_done; int e_len;
    } vec_t;

    vec_t vecs[11];
    int   n_done;

    initial begin
        // Single message, then drain
        vecs[0]  = '{1, 'h48, 0, 1, 'h48, 1, 0, 0};
        vecs[1]  = '{1, 'h49, 0, 2, 'h48, 1, 0, 0};
        vecs[2]  = '{1, 'h21, 0, 3, 'h48, 1, 0, 0};
        vecs[3]  = '{0, 0,    0, 3, 'h48, 1, 0, 0};
        vecs[4]  = '{0, 0,    0, 3, 'h48, 1, 0, 0};
        vecs[5]  = '{0, 0,    0, 3, 'h48, 1, 0, 0};
        vecs[6]  = '{0, 0,    0, 3, 'h48, 1, 1, 3};
        vecs[7]  = '{0, 0,    1, 2, 'h49, 1, 0, 3};
        vecs[8]  = '{0, 0,    1, 1, 'h21, 1, 0, 3};
        vecs[9]  = '{0, 0,    1, 0, 0,    0, 0, 3};
        vecs[10] = '{0, 0,    1, 0, 0,    0, 0, 3};

        // ---- reset ----
        rst = 1'b1;
        drive(0, 0, 0, 0);
        tick();
        tick();
        chk("rst_valid_o",  int'(valid_o),  0);
        chk("rst_empty",    int'(empty),    1);
        chk("rst_level",    int'(level),    0);
        chk("rst_data_o",   int'(data_o),   0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_msg_done", int'(msg_done), 0);
        chk("rst_msg_len",  int'(msg_len),  0);
        #2;
        rst = 1'b0;

        // ---- table vectors ----
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].r, 0);
            tick();
            chk($sformatf("vec%0d_level", i), int'(level),    vecs[i].e_level);
            chk($sformatf("vec%0d_data", i),  int'(data_o),   vecs[i].e_data);
            chk($sformatf("vec%0d_valid", i), int'(valid_o),  int'(vecs[i].e_valid));
            chk($sformatf("vec%0d_done", i),  int'(msg_done), int'(vecs[i].e_done));
            chk($sformatf("vec%0d_len", i),   int'(msg_len),  vecs[i].e_len);
        end

        // ---- overflow: 17 pushes into a 16-entry FIFO ----
        for (int i = 0; i < 17; i++) begin
            drive(1, i, 0, 0);
            tick();
            if (i == 15) begin
                chk("ovf_full16",  int'(full),     1);
                chk("ovf_level16", int'(level),    16);
                chk("ovf_not_yet", int'(overflow), 0);
            end
        end
        chk("ovf_set",       int'(overflow), 1);
        chk("ovf_level",     int'(level),    16);
        chk("ovf_head",      int'(data_o),   0);
        drive(0, 0, 0, 0);
        for (int i = 0; i < IDLE_GAP; i++) tick();
        chk("ovf_msg_done",  int'(msg_done), 1);
        chk("ovf_msg_len",   int'(msg_len),  16);
        drive(0, 0, 0, 1);
        tick();
        chk("ovf_cleared",   int'(overflow), 0);

        // ---- push + pop while full ----
        drive(1, 'hAA, 1, 0);
        tick();
        chk("pp_level",    int'(level),    16);
        chk("pp_no_drop",  int'(overflow), 0);
        chk("pp_head",     int'(data_o),   1);
        drive(0, 0, 1, 0);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("pp_drain%0d", i), int'(data_o), (i < 15) ? i + 1 : 'hAA);
            tick();
        end
        chk("pp_empty", int'(empty), 1);
        for (int i = 0; i < IDLE_GAP; i++) tick();

        // ---- short gap does not close the message ----
        n_done = 0;
        drive(1, 'h41, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        for (int i = 0; i < IDLE_GAP - 1; i++) begin
            tick();
            n_done += int'(msg_done);
        end
        drive(1, 'h42, 0, 0);
        tick();
        n_done += int'(msg_done);
        drive(0, 0, 0, 0);
        for (int i = 0; i < 2 * IDLE_GAP; i++) begin
            tick();
            n_done += int'(msg_done);
            if (msg_done) chk("gap_msg_len", int'(msg_len), 2);
        end
        chk("gap_done_count", n_done, 1);

        // ---- reset in the middle of a message ----
        drive(1, 'h11, 0, 0);
        tick();
        drive(1, 'h22, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_level",   int'(level),   0);
        chk("mrst_msg_len", int'(msg_len), 0);
        chk("mrst_empty",   int'(empty),   1);
        n_done = 0;
        for (int i = 0; i < 2 * IDLE_GAP; i++) begin
            tick();
            n_done += int'(msg_done);
        end
        chk("mrst_no_done", n_done, 0);
        drive(1, 'h33, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        for (int i = 0; i < IDLE_GAP; i++) tick();
        chk("mrst_fresh_done", int'(msg_done), 1);
        chk("mrst_fresh_len",  int'(msg_len),  1);

        // ---- random traffic against the model ----
        for (int phase = 0; phase < 4; phase++) begin
            for (int i = 0; i < 800; i++) begin
                int vprob;
                int rprob;
                vprob = (phase == 0) ? 80 : (phase == 1) ? 30 : (phase == 2) ? 60 : 95;
                rprob = (phase == 0) ? 20 : (phase == 1) ? 70 : (phase == 2) ? 50 : 90;
                drive($urandom_range(99) < vprob,
                      int'($urandom_range(255)),
                      $urandom_range(99) < rprob,
                      $urandom_range(99) < 3);
                rst = ($urandom_range(999) == 0);
                tick();
            end
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_decryption_out_buffer
`default_nettype wire
